plugboard_cfg_ctrl: RTL and testbench

PLUGBOARD_CFG_CTRL -- requirements
Module: plugboard_cfg_ctrl

---
 rtl/plugboard_cfg_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_plugboard_cfg_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/plugboard_cfg_ctrl.sv
// Plugboard configuration controller: validates PLUG/UNPLUG/CLEAR_ALL commands against a shadow table, then writes the LUT.
// Latency accept->rsp: 4 (legal plug/unplug), 2 (error), ALPHABET_LEN+2 (clear); cmd_ready only in IDLE, no queuing.
module plugboard_cfg_ctrl #(
  parameter int ALPHABET_LEN = 26,
  parameter int PORTLEN      = 5,
  parameter int MAX_PLUGS    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [PORTLEN-1:0] cmd_a,
  input  logic [PORTLEN-1:0] cmd_b,
  output logic               lut_we,
  output logic [PORTLEN-1:0] lut_addr,
  output logic [PORTLEN:0]   lut_wdata,
  output logic               rsp_valid,
  output logic [1:0]         rsp_status,
  output logic [3:0]         plug_count,
  output logic               pb_cs_n
);

  typedef enum logic [2:0] {INIT_CLR, IDLE, CHECK, WR_A, WR_B, RESP} state_t;

  localparam logic [1:0] OP_PLUG   = 2'b00;
  localparam logic [1:0] OP_UNPLUG = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_BAD      = 2'b01;
  localparam logic [1:0] ST_CONFLICT = 2'b10;
  localparam logic [1:0] ST_FULL     = 2'b11;

  localparam logic [PORTLEN:0] ALEN = (PORTLEN+1)'(ALPHABET_LEN);
  localparam logic [3:0]       MAXP = 4'(MAX_PLUGS);

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [PORTLEN-1:0]   a_q, a_d, b_q, b_d, partner_q, partner_d;
  logic [PORTLEN:0]     clr_idx_q, clr_idx_d;
  logic                 clr_cmd_q, clr_cmd_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 pb_cs_n_q, pb_cs_n_d;
  logic                 lut_we_q, lut_we_d;
  logic [PORTLEN-1:0]   lut_addr_q, lut_addr_d;
  logic [PORTLEN:0]     lut_wdata_q, lut_wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_status_q, rsp_status_d;
  logic [3:0]           plug_count_q, plug_count_d;
  logic [PORTLEN:0]     shadow_q [ALPHABET_LEN];
  logic [PORTLEN:0]     shadow_d [ALPHABET_LEN];

  logic                 a_bad, b_bad, is_bad, is_conflict, is_full;
  logic [PORTLEN:0]     ent_a, ent_b;

  assign a_bad = {1'b0, a_q} >= ALEN;
  assign b_bad = {1'b0, b_q} >= ALEN;
  assign ent_a = a_bad ? '0 : shadow_q[a_q];
  assign ent_b = b_bad ? '0 : shadow_q[b_q];

  assign is_bad      = (op_q == OP_RSVD) || a_bad ||
                       ((op_q == OP_PLUG) && (b_bad || (a_q == b_q)));
  assign is_conflict = ((op_q == OP_PLUG) && (ent_a[PORTLEN] || ent_b[PORTLEN])) ||
                       ((op_q == OP_UNPLUG) && !ent_a[PORTLEN]);
  assign is_full     = (op_q == OP_PLUG) && (plug_count_q >= MAXP);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    partner_d    = partner_q;
    clr_idx_d    = clr_idx_q;
    clr_cmd_d    = clr_cmd_q;
    rsp_status_d = rsp_status_q;
    plug_count_d = plug_count_q;
    lut_we_d     = 1'b0;
    lut_addr_d   = '0;
    lut_wdata_d  = '0;
    shadow_d     = shadow_q;

    case (state_q)
      INIT_CLR: begin
        if (clr_idx_q < ALEN) begin
          lut_we_d   = 1'b1;
          lut_addr_d = clr_idx_q[PORTLEN-1:0];
          clr_idx_d  = clr_idx_q + 1'b1;
        end else begin
          // Only a CLEAR_ALL command earns a response; the post-reset sweep does not.
          state_d      = clr_cmd_q ? RESP : IDLE;
          rsp_status_d = clr_cmd_q ? ST_OK : rsp_status_q;
          clr_cmd_d    = 1'b0;
        end
      end
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (is_bad) begin
          rsp_status_d = ST_BAD;
          state_d      = RESP;
        end else if (is_conflict) begin
          rsp_status_d = ST_CONFLICT;
          state_d      = RESP;
        end else if (is_full) begin
          rsp_status_d = ST_FULL;
          state_d      = RESP;
        end else if (op_q == OP_CLEAR) begin
          lut_we_d     = 1'b1;
          lut_addr_d   = '0;
          clr_idx_d    = (PORTLEN+1)'(1);
          clr_cmd_d    = 1'b1;
          plug_count_d = '0;
          state_d      = INIT_CLR;
        end else begin
          // Second write target: the new partner for PLUG, the old partner for UNPLUG.
          partner_d   = (op_q == OP_PLUG) ? b_q : ent_a[PORTLEN-1:0];
          lut_we_d    = 1'b1;
          lut_addr_d  = a_q;
          lut_wdata_d = (op_q == OP_PLUG) ? {1'b1, b_q} : '0;
          state_d     = WR_A;
        end
      end
      WR_A: begin
        lut_we_d    = 1'b1;
        lut_addr_d  = partner_q;
        lut_wdata_d = (op_q == OP_PLUG) ? {1'b1, a_q} : '0;
        if (op_q == OP_PLUG) begin
          if (plug_count_q < MAXP) plug_count_d = plug_count_q + 4'd1;
        end else if (plug_count_q != 4'd0) begin
          plug_count_d = plug_count_q - 4'd1;
        end
        state_d = WR_B;
      end
      WR_B: begin
        rsp_status_d = ST_OK;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = INIT_CLR;
    endcase

    if (lut_we_d) shadow_d[lut_addr_d] = lut_wdata_d;

    cmd_ready_d = (state_d == IDLE);
    pb_cs_n_d   = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT_CLR;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      partner_q    <= '0;
      clr_idx_q    <= '0;
      clr_cmd_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      pb_cs_n_q    <= 1'b1;
      lut_we_q     <= 1'b0;
      lut_addr_q   <= '0;
      lut_wdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      plug_count_q <= '0;
      for (int i = 0; i < ALPHABET_LEN; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      partner_q    <= partner_d;
      clr_idx_q    <= clr_idx_d;
      clr_cmd_q    <= clr_cmd_d;
      cmd_ready_q  <= cmd_ready_d;
      pb_cs_n_q    <= pb_cs_n_d;
      lut_we_q     <= lut_we_d;
      lut_addr_q   <= lut_addr_d;
      lut_wdata_q  <= lut_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      plug_count_q <= plug_count_d;
      for (int i = 0; i < ALPHABET_LEN; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign pb_cs_n    = pb_cs_n_q;
  assign lut_we     = lut_we_q;
  assign lut_addr   = lut_addr_q;
  assign lut_wdata  = lut_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign plug_count = plug_count_q;

endmodule

// File: tb/tb_plugboard_cfg_ctrl.sv
// Bench for plugboard_cfg_ctrl: directed and random commands scored against a partner-array model of the plugboard.
module tb_plugboard_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_a = '0, cmd_b = '0;
  logic       lut_we;
  logic [4:0] lut_addr;
  logic [5:0] lut_wdata;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [3:0] plug_count;
  logic       pb_cs_n;

  int n_vec = 0;
  int n_err = 0;
  int pm [26];   // partner of each letter, -1 when unplugged
  int cnt;

  plugboard_cfg_ctrl #(.ALPHABET_LEN(26), .PORTLEN(5), .MAX_PLUGS(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_wdata(lut_wdata), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .plug_count(plug_count), .pb_cs_n(pb_cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_status(input int op, input int a, input int b);
    if (op == 3 || a >= 26 || (op == 0 && (b >= 26 || a == b))) return 1;
    if (op == 0 && (pm[a] >= 0 || pm[b] >= 0)) return 2;
    if (op == 1 && pm[a] < 0) return 2;
    if (op == 0 && cnt == 10) return 3;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 26; i++) pm[i] = -1;
    cnt = 0;
  endtask

  // Caller positions at a negedge; reset is asserted immediately.
  task automatic do_reset(input string tag);
    int oa[$], od[$];
    int rsp_seen, got;
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_ready"}, cmd_ready, 0);
    chk({tag, "_rst_csn"}, pb_cs_n, 1);
    chk({tag, "_rst_we"}, {lut_we, lut_addr, lut_wdata}, 0);
    chk({tag, "_rst_rsp"}, {rsp_valid, rsp_status}, 0);
    chk({tag, "_rst_count"}, plug_count, 0);
    rst = 1'b0;
    model_clear();
    rsp_seen = 0;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (lut_we) begin oa.push_back(lut_addr); od.push_back(lut_wdata); end
      if (rsp_valid) rsp_seen++;
      if (cmd_ready) got = 1;
    end
    chk({tag, "_clr_done"}, got, 1);
    chk({tag, "_clr_nwr"}, oa.size(), 26);
    for (int i = 0; i < oa.size() && i < 26; i++) begin
      chk({tag, "_clr_addr"}, oa[i], i);
      chk({tag, "_clr_data"}, od[i], 0);
    end
    chk({tag, "_clr_rsp"}, rsp_seen, 0);
    chk({tag, "_clr_csn"}, pb_cs_n, 0);
    chk({tag, "_clr_count"}, plug_count, 0);
  endtask

  task automatic run_cmd(input int op, input int a, input int b, input string tag);
    int st, lat, p, got, busy_bad;
    int ea[$], ed[$], oa[$], od[$];
    st = exp_status(op, a, b);
    lat = 2;
    if (st == 0) begin
      if (op == 0) begin
        ea = '{a, b}; ed = '{32 + b, 32 + a}; lat = 4;
        pm[a] = b; pm[b] = a; cnt++;
      end else if (op == 1) begin
        p = pm[a];
        ea = '{a, p}; ed = '{0, 0}; lat = 4;
        pm[a] = -1; pm[p] = -1; cnt--;
      end else begin
        for (int i = 0; i < 26; i++) begin ea.push_back(i); ed.push_back(0); end
        lat = 28;
        model_clear();
      end
    end
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    chk({tag, "_ready"}, got, 1);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_a = 5'(a); cmd_b = 5'(b);
    got = 0; busy_bad = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (lut_we) begin oa.push_back(lut_addr); od.push_back(lut_wdata); end
      else if (lut_addr != 0 || lut_wdata != 0) busy_bad++;
      if (cmd_ready || !pb_cs_n) busy_bad++;
      if (rsp_valid) begin
        got = 1;
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_status"}, rsp_status, st);
        cmd_valid = 1'b0;
      end else begin
        // Busy-time offers must be dropped, not queued.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op = 2'($urandom); cmd_a = 5'($urandom); cmd_b = 5'($urandom);
      end
    end
    cmd_valid = 1'b0;
    chk({tag, "_rsp_seen"}, got, 1);
    chk({tag, "_busy_outputs"}, busy_bad, 0);
    chk({tag, "_count"}, plug_count, cnt);
    chk({tag, "_nwr"}, oa.size(), ea.size());
    for (int i = 0; i < oa.size() && i < ea.size(); i++) begin
      chk({tag, "_wr_addr"}, oa[i], ea[i]);
      chk({tag, "_wr_data"}, od[i], ed[i]);
    end
    @(negedge clk);
    chk({tag, "_back_idle"}, {cmd_ready, pb_cs_n, rsp_valid}, 3'b100);
  endtask

  initial begin
    int r, op, a, b, got;
    model_clear();
    @(negedge clk);
    do_reset("por");

    run_cmd(0, 0, 4, "plug_0_4");
    run_cmd(0, 4, 7, "plug_conflict");
    run_cmd(0, 3, 3, "plug_same");
    run_cmd(0, 26, 1, "plug_a26");
    run_cmd(0, 1, 30, "plug_b30");
    run_cmd(3, 1, 2, "op_rsvd");
    run_cmd(1, 4, 0, "unplug_4");
    run_cmd(1, 4, 0, "unplug_again");

    for (int i = 0; i < 10; i++) run_cmd(0, 2 * i, 2 * i + 1, "fill");
    run_cmd(0, 20, 21, "plug_full");
    run_cmd(0, 0, 22, "full_vs_conflict");
    run_cmd(0, 20, 20, "full_vs_bad");
    run_cmd(1, 19, 0, "unplug_from_full");
    run_cmd(0, 20, 21, "plug_refill");
    run_cmd(2, 0, 0, "clear_all");
    run_cmd(1, 0, 0, "unplug_after_clear");

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      op = (r < 55) ? 0 : (r < 87) ? 1 : (r < 92) ? 2 : 3;
      a = $urandom_range(0, 27);
      b = $urandom_range(0, 27);
      run_cmd(op, a, b, "rand");
    end

    model_clear();
    run_cmd(2, 0, 0, "pre_mid_clear");
    run_cmd(0, 0, 4, "pre_mid_plug");
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    chk("mid_ready", got, 1);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 5'd5; cmd_b = 5'd6;
    got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (lut_we) got = k;
    end
    chk("mid_wr_a_cycle", got, 2);
    chk("mid_wr_a_addr", lut_addr, 5);
    chk("mid_no_rsp", rsp_valid, 0);
    do_reset("mid_rst");
    run_cmd(0, 0, 4, "post_rst_plug");
    run_cmd(0, 5, 6, "post_rst_plug2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
